piso_serializer: RTL

Parallel-in/serial-out serializer that sits directly upstream of the 4-bit SIPO shift register. It accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first, one bit per clock, on a registered serial line. The SIPO shifts left, so MSB-first order makes the word reappear in the SIPO's `parallel_out` with its original bit order after WIDTH shifts. `serial_valid` is the integration-level shift enable for the downstream register.

---
 rtl/piso_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out serializer feeding a left-shifting
// SIPO. Accepts a WIDTH-bit word over a valid/ready handshake and emits it
// MSB-first, one bit per clock, on registered serial_out / serial_valid /
// frame_last lines.
//
// Handshake: a word is taken on a rising edge where load_valid && load_ready
// are both high; load_ready is high only in IDLE while clear is low. The
// upstream source must hold parallel_in stable until it sees load_ready.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit after
// the WIDTH data bits. frame_last then marks the parity bit.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = SHIFT, 2 = PARITY).
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_last,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_CNT  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    ,ST_PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             frame_last_q, frame_last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Ready is combinational so a word can be taken in the single idle cycle.
  assign load_ready   = (state_q == ST_IDLE) && !clear;
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_last   = frame_last_q;
  assign dbg_state    = state_q;

  // Next-state logic: outputs are computed for the bit presented after the edge.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    serial_out_d   = 1'b0;
    serial_valid_d = 1'b0;
    frame_last_d   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d       = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d        = ST_SHIFT;
          shreg_d        = parallel_in;
          cnt_d          = '0;
          serial_out_d   = parallel_in[WIDTH-1];
          serial_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
          parity_d       = ^parallel_in;
`endif
        end
      end

      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q == LAST_CNT) begin
          // Last data bit leaves this edge; counter parks at 0 rather than wrap.
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d        = ST_PARITY;
          serial_out_d   = parity_q;
          serial_valid_d = 1'b1;
          frame_last_d   = 1'b1;
`else
          state_d        = ST_IDLE;
`endif
        end else begin
          cnt_d          = cnt_q + CW'(1);
          serial_out_d   = shreg_q[WIDTH-2];
          serial_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
          frame_last_d   = 1'b0;
`else
          frame_last_d   = (cnt_q == PENULT_CNT);
`endif
        end
      end

`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // clear overrides everything, including a simultaneous load_valid.
    if (clear) begin
      state_d        = ST_IDLE;
      shreg_d        = '0;
      cnt_d          = '0;
      serial_out_d   = 1'b0;
      serial_valid_d = 1'b0;
      frame_last_d   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d       = 1'b0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    state_q        <= state_d;
    shreg_q        <= shreg_d;
    cnt_q          <= cnt_d;
    serial_out_q   <= serial_out_d;
    serial_valid_q <= serial_valid_d;
    frame_last_q   <= frame_last_d;
`ifdef PISO_PARITY_EN
    parity_q       <= parity_d;
`endif
  end

endmodule
